// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the register-file writeback path (8 x 16-bit register file).
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 8;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'd0;

    // One queued writeback is packed as {addr, data}
    localparam int WB_ENTRY_W = REG_ADDR_W + REG_DATA_W;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo #(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; clearing the pointers discards the contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: load returns always win, ALU results queue in wb_fifo.
// Optional macro WB_ALU_BYPASS_EN lets an ALU result skip the empty FIFO for 1-cycle latency.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    parameter  int DATA_W     = REG_DATA_W,
    parameter  int ADDR_W     = REG_ADDR_W,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_issue,
    input  logic [ADDR_W-1:0]   ld_issue_rd,
    input  logic                ld_valid,
    input  logic [ADDR_W-1:0]   ld_rd,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                we,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_REGS-1:0] busy,
    output logic [CNT_W-1:0]    fifo_count
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0]  head;
    logic                fifo_empty;
    logic                alu_acc;
    logic                bypass;
    logic                push;
    logic                pop;
    logic                sel_vld;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] busy_nxt;

    // Ready comes from the registered count only, never from the valids
    assign alu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

    always_comb begin
        fifo_empty = (fifo_count == '0);
        alu_acc    = alu_valid && alu_ready;
        bypass     = 1'b0;
`ifdef WB_ALU_BYPASS_EN
        bypass     = alu_acc && !ld_valid && fifo_empty;
`endif
        push       = alu_acc && !bypass;
        pop        = !ld_valid && !fifo_empty;

        sel_vld  = 1'b1;
        sel_addr = ld_rd;
        sel_data = ld_data;
        if (ld_valid) begin
            sel_vld = 1'b1;
        end else if (!fifo_empty) begin
            {sel_addr, sel_data} = head;
        end else if (bypass) begin
            sel_addr = alu_rd;
            sel_data = alu_data;
        end else begin
            sel_vld = 1'b0;
        end
    end

    // A fresh issue to the same register outranks the returning load's clear
    always_comb begin
        busy_nxt = busy;
        if (ld_valid) begin
            busy_nxt[ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != ADDR_W'(REG_ZERO))) begin
            busy_nxt[ld_issue_rd] = 1'b1;
        end
    end

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({alu_rd, alu_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    // R0 writes still take the slot but never assert we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we      <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
            busy    <= '0;
        end else begin
            we   <= sel_vld && (sel_addr != ADDR_W'(REG_ZERO));
            busy <= busy_nxt;
            if (sel_vld) begin
                rd_addr <= sel_addr;
                rd_data <= sel_data;
            end
        end
    end

endmodule
